// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator for 1280x1024@60 (108 MHz pixel
//               clock). Synchronises the PLL lock flag, runs the horizontal
//               and vertical counters, and registers sync, data enable,
//               coordinates and line/frame start pulses from them (one clock
//               of latency from counter to output).
// Ports       : clk          - pixel clock
//               rst          - asynchronous reset, active-high
//               pll_locked   - PLL lock flag (asynchronous, synchronised here)
//               hsync/vsync  - sync outputs, active level HS_POL / VS_POL
//               de           - high inside the active area
//               x, y         - coordinates of the current output cycle
//               line_start   - one-clock pulse when x==0
//               frame_start  - one-clock pulse when x==0 && y==0
//               frame_cnt    - completed-frame counter
// Options     : VGA_TIMING_FRAME_CNT_EN - when defined, frame_cnt counts
//               frame_start pulses after the first one since run rose;
//               otherwise frame_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 112,
    parameter int   H_BP     = 248,
    parameter int   V_ACTIVE = 1024,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 38,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    // Timing boundaries, all evaluated at elaboration in CW bits.
    localparam logic [CW-1:0] c_H_ACTIVE   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_H_LAST     = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] c_V_ACTIVE   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] c_V_LAST     = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;

    logic          w_run;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_line_start;
    logic          w_frame_start;

    // Two-flop lock synchroniser; r_s2 is the run enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= pll_locked;
            r_s2 <= r_s1;
        end
    end

    assign w_run         = r_s2;
    assign w_h_last      = (r_hcnt == c_H_LAST);
    assign w_v_last      = (r_vcnt == c_V_LAST);
    assign w_de          = (r_hcnt < c_H_ACTIVE) && (r_vcnt < c_V_ACTIVE);
    assign w_hs_act      = (r_hcnt >= c_HS_START) && (r_hcnt < c_HS_END);
    // vsync depends on vcnt only, so it is aligned to whole lines.
    assign w_vs_act      = (r_vcnt >= c_VS_START) && (r_vcnt < c_VS_END);
    assign w_line_start  = (r_hcnt == '0);
    assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);

    // Counters and registered outputs. While run is low everything is held
    // at its reset value, so a relock always restarts a fresh frame at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!w_run) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            de          <= w_de;
            x           <= r_hcnt;
            y           <= r_vcnt;
            line_start  <= w_line_start;
            frame_start <= w_frame_start;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic        r_first_seen;

    // The first frame_start after run rises only arms the counter; every
    // later one counts a completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt  <= 16'h0000;
            r_first_seen <= 1'b0;
        end else if (!w_run) begin
            r_frame_cnt  <= 16'h0000;
            r_first_seen <= 1'b0;
        end else if (w_frame_start) begin
            if (r_first_seen) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_first_seen <= 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen with reduced raster
//               parameters. A reference model predicts the outputs of every
//               clock edge from the pixel index since run started; a monitor
//               pops and compares on the opposite clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int P_HA  = 16;
    localparam int P_HFP = 2;
    localparam int P_HS  = 3;
    localparam int P_HBP = 4;
    localparam int P_VA  = 6;
    localparam int P_VFP = 1;
    localparam int P_VS  = 2;
    localparam int P_VBP = 3;
    localparam int P_CW  = 11;
    localparam int c_HT  = P_HA + P_HFP + P_HS + P_HBP;   // 25
    localparam int c_VT  = P_VA + P_VFP + P_VS + P_VBP;   // 12
    localparam int c_FT  = c_HT * c_VT;                   // 300

    typedef struct packed {
        logic            hs;
        logic            vs;
        logic            de;
        logic [P_CW-1:0] x;
        logic [P_CW-1:0] y;
        logic            ls;
        logic            fs;
        logic [15:0]     fc;
    } exp_t;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            pll_locked = 1'b0;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [P_CW-1:0] x;
    logic [P_CW-1:0] y;
    logic            line_start;
    logic            frame_start;
    logic [15:0]     frame_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (P_HA),
        .H_FP     (P_HFP),
        .H_SYNC   (P_HS),
        .H_BP     (P_HBP),
        .V_ACTIVE (P_VA),
        .V_FP     (P_VFP),
        .V_SYNC   (P_VS),
        .V_BP     (P_VBP),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1),
        .CW       (P_CW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    function automatic exp_t reset_val();
        exp_t e;
        e    = '0;
        e.hs = 1'b0;
        e.vs = 1'b0;
        return e;
    endfunction

    // Expected outputs for the n-th running cycle: n counts pixels from the
    // start of the first frame since run rose.
    function automatic exp_t model(longint n);
        exp_t e;
        int   h;
        int   v;
        h    = int'(n % c_HT);
        v    = int'((n / c_HT) % c_VT);
        e.hs = (h >= P_HA + P_HFP) && (h < P_HA + P_HFP + P_HS);
        e.vs = (v >= P_VA + P_VFP) && (v < P_VA + P_VFP + P_VS);
        e.de = (h < P_HA) && (v < P_VA);
        e.x  = P_CW'(h);
        e.y  = P_CW'(v);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = 16'(n / c_FT);
`else
        e.fc = 16'h0000;
`endif
        return e;
    endfunction

    function automatic exp_t got_val();
        exp_t g;
        g.hs = hsync;
        g.vs = vsync;
        g.de = de;
        g.x  = x;
        g.y  = y;
        g.ls = line_start;
        g.fs = frame_start;
        g.fc = frame_cnt;
        return g;
    endfunction

    // Reference model: lock is seen by the counters two edges after it is
    // sampled; each edge pushes the response expected after that edge.
    initial begin : p_model
        logic   l1;
        logic   l2;
        longint run_len;
        exp_t   e;
        l1      = 1'b0;
        l2      = 1'b0;
        run_len = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                e       = reset_val();
                l1      = 1'b0;
                l2      = 1'b0;
                run_len = 0;
            end else begin
                if (l2) begin
                    e       = model(run_len);
                    run_len = run_len + 1;
                end else begin
                    e       = reset_val();
                    run_len = 0;
                end
                l2 = l1;
                l1 = pll_locked;
            end
            q.push_back(e);
        end
    end

    // Monitor: compares on the falling edge.
    initial begin : p_monitor
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                g = got_val();
                checks++;
                if (g !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL scoreboard t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d exp hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                                 $time, g.hs, g.vs, g.de, g.x, g.y, g.ls, g.fs, g.fc,
                                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    task automatic goto_xy(input int tx, input int ty);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * c_FT && !found; k++) begin
            @(negedge clk);
            if (x == P_CW'(tx) && y == P_CW'(ty)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL goto_xy timeout got x=%0d y=%0d exp x=%0d y=%0d", x, y, tx, ty);
        end
    endtask

    initial begin : p_stim
        exp_t g;
        // Reset held with lock asserted: outputs must stay at reset values.
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        // Several frames of free run.
        repeat (3 * c_FT + 17) @(negedge clk);

        // Lock loss mid-frame, then relock.
        goto_xy(10, 3);
        pll_locked = 1'b0;
        repeat (8) @(negedge clk);
        pll_locked = 1'b1;
        repeat (c_FT + 40) @(negedge clk);

        // Asynchronous reset assertion between clock edges.
        goto_xy(P_HA + P_HFP + 1, P_VA + P_VFP);
        #2 rst = 1'b1;
        #1 g = got_val();
        checks++;
        if (g !== reset_val()) begin
            errors++;
            $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b de=%b exp all zero", g.x, g.y, g.hs, g.vs, g.de);
        end
        @(negedge clk);
        // Release reset while unlocked, lock later.
        pll_locked = 1'b0;
        rst        = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (c_FT / 2) @(negedge clk);

        // Randomised lock glitches, reset pulses and run lengths.
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    pll_locked = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    pll_locked = 1'b1;
                end
                1: begin
                    rst = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    rst = 1'b0;
                end
                default: repeat ($urandom_range(20, 2 * c_FT)) @(negedge clk);
            endcase
        end
        repeat (c_FT + 5) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
